instr_fetch: RTL and testbench

//  Instruction-fetch sequencer for the LEGv8 core: owns the PC, requests 32-bit words from

---
 rtl/fetch_pkg.sv | 16 +
 rtl/pc_next_calc.sv | 21 ++
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam int PC_INC  = 4;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 21;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC selection (sequential or branch target)
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] br_off,
    output logic [ADDR_W-1:0] pc_next
);

    // br_off is a word offset; shifting by two gives bytes, and the sum wraps naturally
    always_comb begin
        pc_next = instr_pc + ADDR_W'(PC_INC);
        if (pc_src) begin
            pc_next = instr_pc + (br_off << 2);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - LEGv8 instruction-fetch sequencer with req/ack memory port
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_err,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                stall,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPC_W-1:0]    opcode,
    output logic [ADDR_W-1:0]   instr_pc,
    input  logic                pc_src,
    input  logic [ADDR_W-1:0]   br_off,
    output logic                fault,
    output logic [31:0]         fetch_count
);

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                fault_q, fault_d;
    logic [31:0]         fetch_count_q, fetch_count_d;
    logic [ADDR_W-1:0]   pc_nxt;
    logic                consume;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next_calc (
        .instr_pc (instr_pc_q),
        .pc_src   (pc_src),
        .br_off   (br_off),
        .pc_next  (pc_nxt)
    );

    // stall wins over instr_ready so a hazard hold can never leak a consume
    assign consume = instr_valid_q & instr_ready & ~stall;

    // next-state and output computation for the fetch FSM
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            ST_IDLE: begin
                state_d     = ST_REQ;
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
            end
            ST_REQ: begin
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    if (imem_err) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = ST_VALID;
                    end
                end
            end
            ST_VALID: begin
                imem_req_d = 1'b0;
                if (consume) begin
                    pc_d          = pc_nxt;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = pc_nxt;
                    instr_valid_d = 1'b0;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = ST_REQ;
                end
            end
            default: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // state and registered outputs; reset drops the request immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= RESET_PC;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_MSB:OPC_LSB];
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a behavioural fetch model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic [63:0] instr_pc;
    logic        pc_src = 1'b0;
    logic [63:0] br_off = '0;
    logic        fault;
    logic [31:0] fetch_count;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state: where the next fetch must go and what is being presented
    logic [63:0] exp_pc    = '0;
    logic [63:0] exp_ipc   = '0;
    logic [31:0] exp_instr = '0;
    logic [31:0] exp_count = '0;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .pc_src      (pc_src),
        .br_off      (br_off),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one memory transaction: waits for the request, optionally delays the ack
    task automatic fetch(input logic [31:0] data, input int waits, input logic err);
        int n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("req_seen", 64'(imem_req), 64'd1);
        chk("imem_addr", imem_addr, exp_pc);
        for (int w = 0; w < waits; w++) begin
            tick();
            chk("req_hold", 64'(imem_req), 64'd1);
            chk("addr_hold", imem_addr, exp_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        imem_err   = err;
        tick();
        imem_ack   = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = $urandom;
        if (!err) begin
            exp_ipc   = exp_pc;
            exp_instr = data;
            chk("valid_up", 64'(instr_valid), 64'd1);
            chk("instr", 64'(instr), 64'(data));
            chk("opcode", 64'(opcode), 64'(data >> 21));
            chk("instr_pc", instr_pc, exp_pc);
            chk("req_drop", 64'(imem_req), 64'd0);
        end else begin
            chk("fault_set", 64'(fault), 64'd1);
            chk("req_drop_err", 64'(imem_req), 64'd0);
            chk("valid_err", 64'(instr_valid), 64'd0);
        end
    endtask

    // hold under stall (with noise on ignored inputs), then consume with the given branch
    task automatic consume(input int stalls, input logic src, input logic [63:0] off);
        for (int s = 0; s < stalls; s++) begin
            stall       = 1'b1;
            instr_ready = 1'b1;
            pc_src      = 1'($urandom);
            br_off      = {$urandom, $urandom};
            imem_ack    = 1'($urandom);
            imem_rdata  = $urandom;
            tick();
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_instr", 64'(instr), 64'(exp_instr));
            chk("stall_ipc", instr_pc, exp_ipc);
            chk("stall_noreq", 64'(imem_req), 64'd0);
            chk("stall_count", 64'(fetch_count), 64'(exp_count));
        end
        stall       = 1'b0;
        instr_ready = 1'b1;
        imem_ack    = 1'b0;
        pc_src      = src;
        br_off      = off;
        tick();
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        br_off      = '0;
        exp_pc    = src ? exp_ipc + off * 64'd4 : exp_ipc + 64'd4;
        exp_count = exp_count + 32'd1;
        chk("count", 64'(fetch_count), 64'(exp_count));
        chk("req_next", 64'(imem_req), 64'd1);
        chk("addr_next", imem_addr, exp_pc);
        chk("valid_down", 64'(instr_valid), 64'd0);
    endtask

    task automatic reset_model();
        exp_pc    = '0;
        exp_ipc   = '0;
        exp_count = '0;
    endtask

    initial begin
        // reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);
        chk("rst_ipc", instr_pc, 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_count", 64'(fetch_count), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        reset_model();

        // 1: IDLE leaves one cycle after release, zero-wait ADD fetch
        tick();
        chk("t1_req", 64'(imem_req), 64'd1);
        chk("t1_valid_lo", 64'(instr_valid), 64'd0);
        fetch(32'h8B02_0020, 0, 1'b0);
        chk("t1_opc_add", 64'(opcode), 64'h458);

        // 2: sequential fetch 0 -> 4 -> 8 -> 12
        consume(0, 1'b0, 64'd0);
        fetch($urandom, 0, 1'b0);
        consume(0, 1'b0, 64'd0);
        fetch($urandom, 1, 1'b0);
        consume(0, 1'b0, 64'd0);
        chk("t2_addr12", imem_addr, 64'd12);
        chk("t2_count3", 64'(fetch_count), 64'd3);

        // 3: backward branch from 16, then large offset from 0, then PC wrap to 0
        fetch($urandom, 0, 1'b0);
        consume(0, 1'b0, 64'd0);
        fetch($urandom, 0, 1'b0);
        consume(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("t3_back8", imem_addr, 64'd8);
        fetch($urandom, 0, 1'b0);
        consume(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        fetch($urandom, 0, 1'b0);
        chk("t3_ipc0", instr_pc, 64'd0);
        consume(0, 1'b1, 64'h3FFF_FFFF_FFFF_FFFF);
        chk("t3_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch($urandom, 0, 1'b0);
        consume(0, 1'b0, 64'd0);
        chk("t3_wrap", imem_addr, 64'd0);

        // 4: five stall cycles with instr_ready high
        fetch($urandom, 0, 1'b0);
        consume(5, 1'b0, 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            int s;
            s = int'($urandom_range(0, 40)) - 20;
            fetch($urandom, int'($urandom_range(0, 2)), 1'b0);
            consume(int'($urandom_range(0, 3)), 1'($urandom), {{32{s[31]}}, s});
        end

        // 5: memory fault is terminal until reset
        fetch($urandom, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            imem_ack    = 1'($urandom);
            imem_err    = 1'($urandom);
            instr_ready = 1'b1;
            tick();
            chk("t5_fault", 64'(fault), 64'd1);
            chk("t5_noreq", 64'(imem_req), 64'd0);
            chk("t5_novalid", 64'(instr_valid), 64'd0);
        end
        imem_ack    = 1'b0;
        imem_err    = 1'b0;
        instr_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_fault_clr", 64'(fault), 64'd0);
        tick();
        rst_n = 1'b1;
        reset_model();
        fetch($urandom, 0, 1'b0);
        consume(0, 1'b0, 64'd0);

        // 6: reset mid-request drops imem_req asynchronously, then refetch from 0
        chk("t6_req_up", 64'(imem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 64'(imem_req), 64'd0);
        chk("t6_addr_rst", imem_addr, 64'd0);
        chk("t6_count_rst", 64'(fetch_count), 64'd0);
        tick();
        rst_n = 1'b1;
        reset_model();
        fetch($urandom, 0, 1'b0);
        consume(1, 1'b0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
